// File: rtl/aes_host_link.sv
// Host byte-stream adapter: packs 16 bytes into an AES link block and unpacks the reply.
// Define AES_HOST_STATS_EN to enable the blocks_done completed-block counter.
module aes_host_link #(
    parameter int BLOCK_BYTES = 16,
    parameter int TIMEOUT     = 4095
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   s_byte,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [7:0]   m_byte,
    output logic         m_valid,
    input  logic         m_ready,
    input  logic         aes_ready,
    input  logic         aes_rft,
    input  logic         aes_key_valid,
    input  logic         aes_key_chg_rq,
    output logic         aes_key_ch,
    output logic [127:0] aes_data_in,
    output logic         aes_data_in_stb,
    output logic         aes_data_out_stb,
    input  logic [127:0] aes_data_out,
    input  logic         aes_data_valid,
    output logic         timeout_err,
    output logic [15:0]  blocks_done
);

    localparam int             TW    = $clog2(TIMEOUT + 1);
    localparam logic [3:0]     LAST  = 4'(BLOCK_BYTES - 1);
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        FILL,
        WAIT_RDY,
        REQ,
        WAIT_OUT,
        DRAIN
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [3:0]     count;
    logic [TW-1:0]  tcnt;
    logic [127:0]   shreg;
    logic           rdy_q;
    logic           key_acked;
    logic           key_hold;
    logic           take;
    logic           give;
    logic           in_stb_d;
    logic           out_stb_d;
    logic           key_ch_d;
    logic           capture;
    logic           tmo;

    // A key change may only cut in between blocks, never mid-fill.
    assign key_hold = aes_key_chg_rq && (count == 4'd0);
    assign s_ready  = rdy_q && !key_hold;
    assign m_valid  = (state == DRAIN);
    assign m_byte   = shreg[127:120];
    assign take     = s_valid && s_ready;
    assign give     = m_valid && m_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FILL;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        in_stb_d  = 1'b0;
        out_stb_d = 1'b0;
        key_ch_d  = 1'b0;
        capture   = 1'b0;
        tmo       = 1'b0;
        unique case (state)
            FILL: begin
                key_ch_d = key_hold && !key_acked;
                if (take && count == LAST) begin
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (aes_ready && aes_rft && aes_key_valid) begin
                    in_stb_d = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                out_stb_d = 1'b1;
                state_d   = WAIT_OUT;
            end
            WAIT_OUT: begin
                if (aes_data_valid) begin
                    capture = 1'b1;
                    state_d = DRAIN;
                end else if (tcnt == TLAST) begin
                    tmo     = 1'b1;
                    state_d = FILL;
                end
            end
            DRAIN: begin
                if (give && count == LAST) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q            <= 1'b0;
            key_acked        <= 1'b0;
            aes_key_ch       <= 1'b0;
            aes_data_in_stb  <= 1'b0;
            aes_data_out_stb <= 1'b0;
            aes_data_in      <= '0;
            shreg            <= '0;
            count            <= 4'd0;
            tcnt             <= '0;
            timeout_err      <= 1'b0;
        end else begin
            rdy_q            <= (state_d == FILL);
            aes_key_ch       <= key_ch_d;
            aes_data_in_stb  <= in_stb_d;
            aes_data_out_stb <= out_stb_d;
            // One ack per request; re-arm once the requester lets go.
            if (key_ch_d) begin
                key_acked <= 1'b1;
            end else if (!aes_key_chg_rq) begin
                key_acked <= 1'b0;
            end
            for (int i = 0; i < 16; i++) begin
                if (take && count == 4'(i)) begin
                    aes_data_in[127-8*i -: 8] <= s_byte;
                end
            end
            if (take || give) begin
                count <= count + 4'd1;
            end
            if (capture) begin
                shreg <= aes_data_out;
            end else if (give) begin
                shreg <= {shreg[119:0], 8'h00};
            end
            if (state == REQ) begin
                tcnt <= '0;
            end else if (state == WAIT_OUT) begin
                tcnt <= tcnt + 1'b1;
            end
            if (tmo) begin
                timeout_err <= 1'b1;
                count       <= 4'd0;
            end
        end
    end

`ifdef AES_HOST_STATS_EN
    logic        done;
    logic [15:0] done_cnt;

    assign done = give && (count == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_cnt <= 16'h0000;
        end else if (done) begin
            done_cnt <= done_cnt + 16'h0001;
        end
    end

    assign blocks_done = done_cnt;
`else
    assign blocks_done = 16'h0000;
`endif

endmodule

// File: tb/tb_aes_host_link.sv
// Directed testbench for aes_host_link: fill, link handshake, drain, timeout, key change, reset.
// Runs with TIMEOUT=15; blocks_done expectations follow AES_HOST_STATS_EN.
module tb_aes_host_link;

`ifdef AES_HOST_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [7:0]   s_byte = 8'h00;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [7:0]   m_byte;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic         aes_ready = 1'b0;
    logic         aes_rft = 1'b0;
    logic         aes_key_valid = 1'b0;
    logic         aes_key_chg_rq = 1'b0;
    logic         aes_key_ch;
    logic [127:0] aes_data_in;
    logic         aes_data_in_stb;
    logic         aes_data_out_stb;
    logic [127:0] aes_data_out = '0;
    logic         aes_data_valid = 1'b0;
    logic         timeout_err;
    logic [15:0]  blocks_done;

    int compared = 0;
    int mismatched = 0;
    int exp_blocks = 0;
    int ch_pulses = 0;
    logic [7:0] rx[16];
    int rx_n;
    int rx_bad;

    aes_host_link #(.BLOCK_BYTES(16), .TIMEOUT(15)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .s_byte(s_byte),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .m_byte(m_byte),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .aes_ready(aes_ready),
        .aes_rft(aes_rft),
        .aes_key_valid(aes_key_valid),
        .aes_key_chg_rq(aes_key_chg_rq),
        .aes_key_ch(aes_key_ch),
        .aes_data_in(aes_data_in),
        .aes_data_in_stb(aes_data_in_stb),
        .aes_data_out_stb(aes_data_out_stb),
        .aes_data_out(aes_data_out),
        .aes_data_valid(aes_data_valid),
        .timeout_err(timeout_err),
        .blocks_done(blocks_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (aes_key_ch === 1'b1) ch_pulses++;
    end

    function automatic logic [15:0] exp_bd();
        return STATS ? 16'(exp_blocks) : 16'h0000;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int g;
        g = 0;
        s_byte = b;
        s_valid = 1'b1;
        #1;
        while (s_ready !== 1'b1 && g < 200) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 200) begin
            compared++;
            mismatched++;
            $display("FAIL push_bound s_ready=%b required=1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic push_block(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) push_byte(base + 8'(k));
    endtask

    task automatic wait_in_stb();
        int g;
        g = 0;
        while (aes_data_in_stb !== 1'b1 && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) begin
            compared++;
            mismatched++;
            $display("FAIL in_stb_bound stb=%b required=1", aes_data_in_stb);
        end
    endtask

    task automatic link_cycle(input logic [127:0] d, input int delay);
        wait_in_stb();
        @(negedge clk);
        repeat (delay) @(negedge clk);
        aes_data_out = d;
        aes_data_valid = 1'b1;
        @(negedge clk);
        aes_data_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle, input int limit);
        int cyc;
        logic held;
        logic [7:0] hb;
        cyc = 0;
        held = 1'b0;
        hb = 8'h00;
        rx_n = 0;
        rx_bad = 0;
        while (rx_n < limit && cyc < 400) begin
            m_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            #1;
            if (m_valid === 1'b1) begin
                if (held && m_byte !== hb) rx_bad++;
                if (m_ready) begin
                    rx[rx_n] = m_byte;
                    rx_n++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hb = m_byte;
                end
            end
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        if (rx_n < limit) begin
            compared++;
            mismatched++;
            $display("FAIL drain_bound bytes=%0d required=%0d", rx_n, limit);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        compared++;
        if ({s_ready, m_valid, m_byte, aes_data_in_stb, aes_data_out_stb,
             aes_key_ch, timeout_err} !== 14'h0) begin
            mismatched++;
            $display("FAIL reset_ctrl got=%b/%b/%h/%b%b%b/%b required=0",
                     s_ready, m_valid, m_byte, aes_data_in_stb,
                     aes_data_out_stb, aes_key_ch, timeout_err);
        end
        compared++;
        if (aes_data_in !== 128'h0) begin
            mismatched++;
            $display("FAIL reset_data_in got=%h required=0", aes_data_in);
        end
        compared++;
        if (blocks_done !== 16'h0) begin
            mismatched++;
            $display("FAIL reset_blocks got=%h required=0", blocks_done);
        end
        reset_n = 1'b1;
        @(negedge clk);
        compared++;
        if (s_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL post_reset_s_ready got=%b required=1", s_ready);
        end
    endtask

    task automatic test_single_block();
        logic [127:0] d;
        logic [127:0] ein;
        d = 128'hFFEEDDCCBBAA99887766554433221100;
        ein = 128'h000102030405060708090A0B0C0D0E0F;
        aes_ready = 1'b1;
        aes_rft = 1'b1;
        aes_key_valid = 1'b1;
        push_block(8'h00, 16);
        compared++;
        if (aes_data_in !== ein) begin
            mismatched++;
            $display("FAIL single_data_in got=%h required=%h", aes_data_in, ein);
        end
        compared++;
        if ({aes_data_in_stb, s_ready} !== 2'b00) begin
            mismatched++;
            $display("FAIL single_after_fill stb/s_ready=%b%b required=00",
                     aes_data_in_stb, s_ready);
        end
        @(negedge clk);
        compared++;
        if ({aes_data_in_stb, aes_data_out_stb} !== 2'b10) begin
            mismatched++;
            $display("FAIL single_in_stb got=%b%b required=10",
                     aes_data_in_stb, aes_data_out_stb);
        end
        @(negedge clk);
        compared++;
        if ({aes_data_in_stb, aes_data_out_stb} !== 2'b01) begin
            mismatched++;
            $display("FAIL single_out_stb got=%b%b required=01",
                     aes_data_in_stb, aes_data_out_stb);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if ({aes_data_in_stb, aes_data_out_stb, m_valid} !== 3'b000) begin
                mismatched++;
                $display("FAIL single_wait cyc=%0d got=%b%b%b required=000", i,
                         aes_data_in_stb, aes_data_out_stb, m_valid);
            end
        end
        aes_data_out = d;
        aes_data_valid = 1'b1;
        @(negedge clk);
        aes_data_valid = 1'b0;
        compared++;
        if ({m_valid, m_byte} !== 9'h1FF) begin
            mismatched++;
            $display("FAIL single_first_out got=%b/%h required=1/ff", m_valid, m_byte);
        end
        drain(1'b0, 16);
        for (int k = 0; k < 16; k++) begin
            compared++;
            if (rx[k] !== d[127-8*k -: 8]) begin
                mismatched++;
                $display("FAIL single_byte%0d got=%h required=%h", k, rx[k], d[127-8*k -: 8]);
            end
        end
        exp_blocks++;
        compared++;
        if ({m_valid, s_ready, blocks_done} !== {2'b01, exp_bd()}) begin
            mismatched++;
            $display("FAIL single_end got=%b/%b/%h required=0/1/%h",
                     m_valid, s_ready, blocks_done, exp_bd());
        end
    endtask

    task automatic test_link_not_ready();
        logic [127:0] d;
        d = 128'h0123456789ABCDEFFEDCBA9876543210;
        aes_rft = 1'b0;
        push_block(8'h20, 16);
        for (int i = 0; i < 50; i++) begin
            compared++;
            if ({aes_data_in_stb, s_ready} !== 2'b00) begin
                mismatched++;
                $display("FAIL stall cyc=%0d stb/s_ready=%b%b required=00",
                         i, aes_data_in_stb, s_ready);
            end
            @(negedge clk);
        end
        aes_rft = 1'b1;
        @(negedge clk);
        compared++;
        if (aes_data_in_stb !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_release stb=%b required=1", aes_data_in_stb);
        end
        @(negedge clk);
        compared++;
        if (aes_data_out_stb !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_out_stb got=%b required=1", aes_data_out_stb);
        end
        aes_data_out = d;
        aes_data_valid = 1'b1;
        @(negedge clk);
        aes_data_valid = 1'b0;
        compared++;
        if (m_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL same_cycle_valid m_valid=%b required=1", m_valid);
        end
        drain(1'b0, 16);
        for (int k = 0; k < 16; k++) begin
            compared++;
            if (rx[k] !== d[127-8*k -: 8]) begin
                mismatched++;
                $display("FAIL stall_byte%0d got=%h required=%h", k, rx[k], d[127-8*k -: 8]);
            end
        end
        exp_blocks++;
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        d = 128'hA5A55A5A0F0FF0F0123456789ABCDEF0;
        push_block(8'h30, 16);
        link_cycle(d, 2);
        drain(1'b1, 16);
        compared++;
        if (rx_bad !== 0) begin
            mismatched++;
            $display("FAIL bp_stability unstable=%0d required=0", rx_bad);
        end
        for (int k = 0; k < 16; k++) begin
            compared++;
            if (rx[k] !== d[127-8*k -: 8]) begin
                mismatched++;
                $display("FAIL bp_byte%0d got=%h required=%h", k, rx[k], d[127-8*k -: 8]);
            end
        end
        exp_blocks++;
        compared++;
        if ({m_valid, blocks_done} !== {1'b0, exp_bd()}) begin
            mismatched++;
            $display("FAIL bp_end got=%b/%h required=0/%h", m_valid, blocks_done, exp_bd());
        end
    endtask

    task automatic test_timeout();
        push_block(8'h50, 16);
        wait_in_stb();
        @(negedge clk);
        compared++;
        if (aes_data_out_stb !== 1'b1) begin
            mismatched++;
            $display("FAIL to_out_stb got=%b required=1", aes_data_out_stb);
        end
        for (int i = 1; i < 15; i++) begin
            @(negedge clk);
            compared++;
            if ({timeout_err, m_valid} !== 2'b00) begin
                mismatched++;
                $display("FAIL to_early cyc=%0d err/m_valid=%b%b required=00",
                         i, timeout_err, m_valid);
            end
        end
        @(negedge clk);
        compared++;
        if ({timeout_err, s_ready, blocks_done} !== {2'b11, exp_bd()}) begin
            mismatched++;
            $display("FAIL to_fire got=%b/%b/%h required=1/1/%h",
                     timeout_err, s_ready, blocks_done, exp_bd());
        end
        aes_data_valid = 1'b1;
        @(negedge clk);
        aes_data_valid = 1'b0;
        compared++;
        if ({m_valid, timeout_err} !== 2'b01) begin
            mismatched++;
            $display("FAIL to_stray_valid m_valid/err=%b%b required=01", m_valid, timeout_err);
        end
    endtask

    task automatic test_key_change();
        int p0;
        logic [127:0] d;
        d = 128'hDEADBEEFCAFEBABE0011223344556677;
        p0 = ch_pulses;
        aes_key_chg_rq = 1'b1;
        #1;
        compared++;
        if (s_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL key0_s_ready got=%b required=0", s_ready);
        end
        @(negedge clk);
        compared++;
        if (aes_key_ch !== 1'b1) begin
            mismatched++;
            $display("FAIL key0_ack got=%b required=1", aes_key_ch);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if ({aes_key_ch, s_ready} !== 2'b00) begin
                mismatched++;
                $display("FAIL key0_hold cyc=%0d ch/s_ready=%b%b required=00",
                         i, aes_key_ch, s_ready);
            end
        end
        aes_key_chg_rq = 1'b0;
        #1;
        compared++;
        if (s_ready !== 1'b1 || ch_pulses - p0 !== 1) begin
            mismatched++;
            $display("FAIL key0_release s_ready=%b pulses=%0d required=1/1",
                     s_ready, ch_pulses - p0);
        end
        @(negedge clk);
        push_block(8'h60, 7);
        aes_key_chg_rq = 1'b1;
        p0 = ch_pulses;
        #1;
        compared++;
        if (s_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL key7_s_ready got=%b required=1", s_ready);
        end
        push_block(8'h67, 9);
        link_cycle(d, 1);
        drain(1'b0, 16);
        exp_blocks++;
        compared++;
        if (ch_pulses - p0 !== 0 || s_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL key7_deferred pulses=%0d s_ready=%b required=0/0",
                     ch_pulses - p0, s_ready);
        end
        compared++;
        if (rx[15] !== d[7:0]) begin
            mismatched++;
            $display("FAIL key7_last_byte got=%h required=%h", rx[15], d[7:0]);
        end
        @(negedge clk);
        compared++;
        if (aes_key_ch !== 1'b1) begin
            mismatched++;
            $display("FAIL key7_ack got=%b required=1", aes_key_ch);
        end
        aes_key_chg_rq = 1'b0;
        @(negedge clk);
        compared++;
        if (ch_pulses - p0 !== 1 || s_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL key7_end pulses=%0d s_ready=%b required=1/1",
                     ch_pulses - p0, s_ready);
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] d;
        logic [127:0] ein;
        d = 128'h11112222333344445555666677778888;
        for (int k = 0; k < 16; k++) ein[127-8*k -: 8] = 8'h40 + 8'(k);
        push_block(8'h70, 16);
        link_cycle(d, 0);
        drain(1'b0, 6);
        compared++;
        if (rx[5] !== d[87:80]) begin
            mismatched++;
            $display("FAIL rst_pre_byte5 got=%h required=%h", rx[5], d[87:80]);
        end
        #2;
        reset_n = 1'b0;
        #1;
        exp_blocks = 0;
        compared++;
        if ({m_valid, s_ready, m_byte, aes_data_in_stb, aes_data_out_stb,
             aes_key_ch, timeout_err} !== 14'h0) begin
            mismatched++;
            $display("FAIL rst_mid_ctrl got=%b/%b/%h/%b%b%b/%b required=0",
                     m_valid, s_ready, m_byte, aes_data_in_stb,
                     aes_data_out_stb, aes_key_ch, timeout_err);
        end
        compared++;
        if (aes_data_in !== 128'h0 || blocks_done !== 16'h0) begin
            mismatched++;
            $display("FAIL rst_mid_data got=%h/%h required=0/0", aes_data_in, blocks_done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push_block(8'h40, 16);
        compared++;
        if (aes_data_in !== ein) begin
            mismatched++;
            $display("FAIL rst_fresh_block got=%h required=%h", aes_data_in, ein);
        end
        link_cycle(d, 3);
        drain(1'b0, 16);
        for (int k = 0; k < 16; k++) begin
            compared++;
            if (rx[k] !== d[127-8*k -: 8]) begin
                mismatched++;
                $display("FAIL rst_byte%0d got=%h required=%h", k, rx[k], d[127-8*k -: 8]);
            end
        end
        exp_blocks++;
        compared++;
        if (blocks_done !== exp_bd()) begin
            mismatched++;
            $display("FAIL rst_blocks got=%h required=%h", blocks_done, exp_bd());
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_link_not_ready();
        test_backpressure();
        test_timeout();
        test_key_change();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
